// File: rtl/echo_indication_input_if.sv
// Pipe beat input and heard-indication output of the echo indication receiver.
// The slave modport is the receiver's view; master is the transport/consumer side.
interface echo_indication_input_if #(
  parameter int unsigned DataWidth = 32
);
  logic                   enq_ena;
  logic [3*DataWidth-1:0] enq_v;
  logic                   enq_rdy;
  logic                   heard_ena;
  logic [DataWidth-1:0]   heard_meth;
  logic [DataWidth-1:0]   heard_v;
  logic                   heard_rdy;

  modport slave (
    input  enq_ena,
    input  enq_v,
    output enq_rdy,
    output heard_ena,
    output heard_meth,
    output heard_v,
    input  heard_rdy
  );

  modport master (
    output enq_ena,
    output enq_v,
    input  enq_rdy,
    input  heard_ena,
    input  heard_meth,
    input  heard_v,
    output heard_rdy
  );
endinterface

// File: rtl/echo_indication_input.sv
// Echo indication receiver: decodes heard beats into a 2-entry ping-pong buffer.
// Define ECHO_INPUT_ERRCNT_EN to add the saturating drop_count port for bad-tag beats.
module echo_indication_input #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned TagHeard    = 1,
  parameter int unsigned ErrcntWidth = 16
) (
  input logic clk,
  input logic rst,
  echo_indication_input_if.slave bus
`ifdef ECHO_INPUT_ERRCNT_EN
  ,
  output logic [ErrcntWidth-1:0] drop_count
`endif
);

  logic [DataWidth-1:0] in_v;
  logic [DataWidth-1:0] in_meth;
  logic [DataWidth-1:0] in_tag;

  logic [DataWidth-1:0] slot_meth_q [2];
  logic [DataWidth-1:0] slot_v_q    [2];
  logic                 wptr_q;
  logic                 rptr_q;
  logic [1:0]           count_q;
  logic [1:0]           count_d;

  logic enq_fire;
  logic tag_ok;
  logic push;
  logic deq;

  assign in_v    = bus.enq_v[3*DataWidth-1:2*DataWidth];
  assign in_meth = bus.enq_v[2*DataWidth-1:DataWidth];
  assign in_tag  = bus.enq_v[DataWidth-1:0];

  always_comb begin
    bus.enq_rdy    = (count_q != 2'd2);
    bus.heard_ena  = (count_q != 2'd0);
    bus.heard_meth = '0;
    bus.heard_v    = '0;
    if (count_q != 2'd0) begin
      bus.heard_meth = slot_meth_q[rptr_q];
      bus.heard_v    = slot_v_q[rptr_q];
    end
  end

  // Bad-tag beats still fire the enqueue handshake but never touch the buffer.
  assign enq_fire = bus.enq_ena & bus.enq_rdy;
  assign tag_ok   = (in_tag == DataWidth'(TagHeard));
  assign push     = enq_fire & tag_ok;
  assign deq      = bus.heard_ena & bus.heard_rdy;

  always_comb begin
    count_d = count_q;
    case ({push, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_meth_q[0] <= '0;
      slot_meth_q[1] <= '0;
      slot_v_q[0]    <= '0;
      slot_v_q[1]    <= '0;
      wptr_q         <= 1'b0;
      rptr_q         <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      if (push) begin
        slot_meth_q[wptr_q] <= in_meth;
        slot_v_q[wptr_q]    <= in_v;
        wptr_q              <= ~wptr_q;
      end
      if (deq) begin
        rptr_q <= ~rptr_q;
      end
      count_q <= count_d;
    end
  end

`ifdef ECHO_INPUT_ERRCNT_EN
  logic [ErrcntWidth-1:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (enq_fire && !tag_ok && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_echo_indication_input.sv
// Scoreboard bench for echo_indication_input: heard calls are checked in order against
// beats recorded when the pipe accepts them.
module tb_echo_indication_input;
  localparam int unsigned DataWidth   = 32;
  localparam int unsigned TagHeard    = 1;
  localparam int unsigned ErrcntWidth = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [2*DataWidth-1:0] sb_q [$];
  logic [2*DataWidth-1:0] mon_exp;

  echo_indication_input_if #(.DataWidth(DataWidth)) bus ();

`ifdef ECHO_INPUT_ERRCNT_EN
  logic [ErrcntWidth-1:0] drop_count;
`endif

  echo_indication_input #(
    .DataWidth  (DataWidth),
    .TagHeard   (TagHeard),
    .ErrcntWidth(ErrcntWidth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ECHO_INPUT_ERRCNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Every delivered call is popped and compared against the recorded beat order.
  always @(negedge clk) begin
    if (!rst && bus.heard_ena === 1'b1 && bus.heard_rdy === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got meth=%h v=%h, required no call",
                 bus.heard_meth, bus.heard_v);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({bus.heard_meth, bus.heard_v} !== mon_exp) begin
          n_err++;
          $display("FAIL sb_order: got meth=%h v=%h, required meth=%h v=%h",
                   bus.heard_meth, bus.heard_v, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds a beat on the pipe until accepted; records heard beats in the scoreboard.
  task automatic drive_beat(input logic [31:0] v, input logic [31:0] meth,
                            input logic [31:0] tag);
    bit done;
    done = 1'b0;
    bus.enq_ena = 1'b1;
    bus.enq_v   = {v, meth, tag};
    for (int k = 0; k < 50 && !done; k++) begin
      if (bus.enq_rdy === 1'b1) begin
        done = 1'b1;
        if (tag == TagHeard) sb_q.push_back({meth, v});
      end
      step();
    end
    bus.enq_ena = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL enq_timeout: beat meth=%h never accepted", meth);
    end
  endtask

  task automatic drain();
    bus.heard_rdy = 1'b1;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) step();
    step();
    n_cmp++;
    if (sb_q.size() != 0 || bus.heard_ena !== 1'b0) begin
      n_err++;
      $display("FAIL drain: got pending=%0d heard_ena=%b, required 0 and 0",
               sb_q.size(), bus.heard_ena);
    end
  endtask

  task automatic test_reset();
    bus.enq_ena   = 1'b0;
    bus.enq_v     = '0;
    bus.heard_rdy = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (bus.enq_rdy !== 1'b1) begin
      n_err++; $display("FAIL reset_rdy: got %b, required 1", bus.enq_rdy);
    end
    n_cmp++;
    if (bus.heard_ena !== 1'b0) begin
      n_err++; $display("FAIL reset_ena: got %b, required 0", bus.heard_ena);
    end
    n_cmp++;
    if (bus.heard_meth !== 32'h0 || bus.heard_v !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: got meth=%h v=%h, required 0 0", bus.heard_meth, bus.heard_v);
    end
`ifdef ECHO_INPUT_ERRCNT_EN
    n_cmp++;
    if (drop_count !== '0) begin
      n_err++; $display("FAIL reset_drop: got %h, required 0", drop_count);
    end
`endif
  endtask

  task automatic test_single();
    bus.heard_rdy = 1'b1;
    n_cmp++;
    if (bus.heard_ena !== 1'b0) begin
      n_err++; $display("FAIL single_pre: got heard_ena=%b, required 0", bus.heard_ena);
    end
    drive_beat(32'h11, 32'h22, 32'd1);
    n_cmp++;
    if (bus.heard_ena !== 1'b1 || bus.heard_meth !== 32'h22 || bus.heard_v !== 32'h11) begin
      n_err++;
      $display("FAIL single_out: got ena=%b meth=%h v=%h, required 1 22 11",
               bus.heard_ena, bus.heard_meth, bus.heard_v);
    end
    step();
    n_cmp++;
    if (bus.heard_ena !== 1'b0 || bus.heard_meth !== 32'h0) begin
      n_err++;
      $display("FAIL single_empty: got ena=%b meth=%h, required 0 0",
               bus.heard_ena, bus.heard_meth);
    end
  endtask

  task automatic test_backpressure();
    bus.heard_rdy = 1'b0;
    drive_beat(32'hA0, 32'hA1, 32'd1);
    n_cmp++;
    if (bus.enq_rdy !== 1'b1) begin
      n_err++; $display("FAIL bp_rdy_one: got %b, required 1", bus.enq_rdy);
    end
    drive_beat(32'hB0, 32'hB1, 32'd1);
    bus.enq_ena = 1'b1;
    bus.enq_v   = {32'hC0, 32'hC1, 32'd1};
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.enq_rdy !== 1'b0 || bus.heard_ena !== 1'b1 || bus.heard_meth !== 32'hA1) begin
        n_err++;
        $display("FAIL bp_full: got rdy=%b ena=%b meth=%h, required 0 1 a1",
                 bus.enq_rdy, bus.heard_ena, bus.heard_meth);
      end
      step();
    end
    // Dequeue in a full cycle must not raise RDY in the same cycle.
    bus.heard_rdy = 1'b1;
    #1;
    n_cmp++;
    if (bus.enq_rdy !== 1'b0) begin
      n_err++; $display("FAIL bp_no_bypass: got rdy=%b, required 0", bus.enq_rdy);
    end
    drive_beat(32'hC0, 32'hC1, 32'd1);
    drain();
  endtask

  task automatic test_bad_tag();
    logic [ErrcntWidth-1:0] drop_before;
    logic [31:0] bad_tags [3];
    bad_tags[0] = 32'd7;
    bad_tags[1] = 32'd0;
    bad_tags[2] = 32'h8000_0001;
    drop_before = '0;
`ifdef ECHO_INPUT_ERRCNT_EN
    drop_before = drop_count;
`endif
    bus.heard_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bus.enq_rdy !== 1'b1) begin
        n_err++; $display("FAIL bad_rdy: got %b, required 1", bus.enq_rdy);
      end
      drive_beat(32'h5A, 32'h77 + i, bad_tags[i]);
      n_cmp++;
      if (bus.heard_ena !== 1'b0) begin
        n_err++;
        $display("FAIL bad_tag_ena: tag=%h got heard_ena=%b, required 0", bad_tags[i],
                 bus.heard_ena);
      end
    end
`ifdef ECHO_INPUT_ERRCNT_EN
    n_cmp++;
    if (drop_count !== drop_before + 3) begin
      n_err++; $display("FAIL bad_drop: got %h, required %h", drop_count, drop_before + 3);
    end
    bus.enq_ena = 1'b1;
    bus.enq_v   = {32'h0, 32'h0, 32'd7};
    while (drop_count != '1) step();
    for (int k = 0; k < 4; k++) step();
    bus.enq_ena = 1'b0;
    n_cmp++;
    if (drop_count !== '1) begin
      n_err++; $display("FAIL drop_saturate: got %h, required ffff", drop_count);
    end
`endif
    drive_beat(32'h33, 32'h44, 32'd1);
    drain();
  endtask

  task automatic test_streaming();
    bus.heard_rdy = 1'b1;
    bus.enq_ena   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.enq_v = {~i[31:0], i[31:0], 32'd1};
      n_cmp++;
      if (bus.enq_rdy !== 1'b1) begin
        n_err++; $display("FAIL stream_rdy: beat %0d got rdy=%b, required 1", i, bus.enq_rdy);
      end
      if (i > 0) begin
        n_cmp++;
        if (bus.heard_ena !== 1'b1 || bus.heard_meth !== 32'(i - 1)) begin
          n_err++;
          $display("FAIL stream_call: beat %0d got ena=%b meth=%h, required 1 %h",
                   i, bus.heard_ena, bus.heard_meth, 32'(i - 1));
        end
      end
      if (bus.enq_rdy === 1'b1) sb_q.push_back({i[31:0], ~i[31:0]});
      step();
    end
    bus.enq_ena = 1'b0;
    drain();
  endtask

  task automatic test_async_reset();
    bus.heard_rdy = 1'b0;
    drive_beat(32'hD0, 32'hD1, 32'd1);
    drive_beat(32'hE0, 32'hE1, 32'd1);
    n_cmp++;
    if (bus.enq_rdy !== 1'b0 || bus.heard_ena !== 1'b1) begin
      n_err++;
      $display("FAIL arst_full: got rdy=%b ena=%b, required 0 1", bus.enq_rdy, bus.heard_ena);
    end
    #2;
    rst = 1'b1;
    #1;
    sb_q.delete();
    n_cmp++;
    if (bus.heard_ena !== 1'b0 || bus.enq_rdy !== 1'b1 || bus.heard_meth !== 32'h0) begin
      n_err++;
      $display("FAIL arst_immediate: got ena=%b rdy=%b meth=%h, required 0 1 0",
               bus.heard_ena, bus.enq_rdy, bus.heard_meth);
    end
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (bus.heard_ena !== 1'b0) begin
      n_err++; $display("FAIL arst_after: got ena=%b, required 0", bus.heard_ena);
    end
    bus.heard_rdy = 1'b1;
    drive_beat(32'hF0, 32'hF1, 32'd1);
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_bad_tag();
    test_streaming();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
